pipelined_cla_addsub: RTL and testbench
=======================================

Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the integer datapath.
- Generalises the 16-bit four-group lookahead adder in four ways:
  - configurable width;
  - configurable pipeline depth, with the carry registered between segments;
  - add/sub mode;
  - valid/ready handshake with backpressure and flush.
- Sits between operand select and writeback for multi-cycle ALU ops and the address-generation path.

Parameters:
- WIDTH, 32: operand/result width. Must equal STAGES × SEG, with SEG a multiple of 4.
- STAGES, 2: pipeline stages. Each stage resolves one SEG = WIDTH/STAGES-bit segment. Latency = STAGES cycles.
- GROUP, 4: bits per lookahead group inside a segment. Must divide SEG.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; kills all in-flight ops
- in_valid  in  1  operands present
- in_ready  out  1  block can accept this cycle
- op  in  1  adder_pkg::op_e: OP_ADD=0, OP_SUB=1
- cin  in  1  carry-in (ADD) / borrow-complement-in (SUB)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB
- overflow  out  1  signed overflow
- zero  out  1  sum == 0
- negative  out  1  sum[WIDTH-1]

Behaviour:
- Operation:
  - ADD: sum = a + b + cin.
  - SUB: sum = a + ~b + cin. Caller drives cin=1 for a plain subtract; cin=0 gives a - b - 1 (borrow chain).
  - cout is the raw carry out of the MSB. For SUB, cout=1 means no borrow.
  - overflow = carry into MSB XOR carry out of MSB.
- Inside a segment:
  - Groups of GROUP bits produce G/P.
  - Group carries are full lookahead from the segment carry-in: G_i | P_i & (G_{i-1} | ...).
  - No ripple between groups.
- Pipeline (skewed):
  - Stage k (0..STAGES-1) holds, in registers:
    - valid_k;
    - result bits [SEG·(k+1)-1 : 0];
    - registered segment carry c_k;
    - MSB carry-in (last stage only);
    - the upper operand bits still to be processed, already inverted for SUB.
  - Stage 0 is computed combinationally from the inputs at acceptance.
  - Stage k adds segment k using c_{k-1} from stage k-1's register.
  - Outputs are driven from the last stage's registers. zero and negative are computed from the registered sum.
- Latency: a transfer accepted at edge N (in_valid & in_ready) presents out_valid=1 after edge N+STAGES-1, i.e. first visible in cycle N+STAGES, provided there are no stalls.
- Handshake:
  - Stage k advances when valid_k & (stage k+1 empty or advancing); the last stage advances on out_ready.
  - in_ready = !valid_0 | stage 0 advancing. This is combinational from out_ready through the chain; no skid buffer.
  - A stalled stage holds all its data stable.
  - out_valid, once asserted, stays high with sum/cout/overflow/zero/negative stable until out_ready.
  - Throughput is one op/cycle when out_ready is held high.
- Reset (rst_n low, async):
  - All valid_k = 0, so out_valid=0 and in_ready=1 once rst_n is released.
  - sum=0, cout=0, overflow=0, negative=0, zero=1. These are derived from the zeroed sum register.
  - Data registers are reset as well.
  - Reset mid-operation discards all in-flight ops; nothing is emitted after release.
- Flush:
  - Synchronous, takes priority over everything: clears all valid_k at the next edge.
  - in_ready is forced 0 during the flush cycle, so the same-cycle in_valid is not accepted.
  - Data registers are not required to clear.
- Boundary conditions:
  - Full: all STAGES valid with out_ready=0 gives in_ready=0.
  - Simultaneous accept and emit when full and out_ready=1 is legal; occupancy is unchanged.
  - Wrap: 0xFFFFFFFF + 1 gives sum=0, cout=1, zero=1, overflow=0.
  - STAGES=1 degenerates to a registered single-cycle adder; the handshake rules are unchanged.
- Elaboration checks: an elaboration-time assertion fails if WIDTH % STAGES != 0, or SEG % GROUP != 0, or GROUP % 4 != 0.

Decomposition:
- Package adder_pkg:
  - op_e enum;
  - a function for the lookahead carry of a G/P vector;
  - default width localparams.
- Sub-module cla_segment:
  - combinational, parameter SEG/GROUP;
  - inputs a, b, cin; outputs sum, G, P, cout, c_msb (carry into the segment MSB);
  - instantiated STAGES times.
- Top holds only the pipeline registers, operand inversion and handshake logic.

Test Plan:
- WIDTH=32, STAGES=2, ADD: a=0x0000FFFF, b=0x00000001, cin=0 → after 2 cycles sum=0x00010000, cout=0, overflow=0. This checks carry crossing the segment boundary.
- SUB: a=0x80000000, b=1, cin=1 → sum=0x7FFFFFFF, cout=1, overflow=1, negative=0.
- ADD: a=0xFFFFFFFF, b=0, cin=1 → sum=0, cout=1, zero=1, overflow=0.
- Back-to-back 8 ops with out_ready=1 → 8 results on 8 consecutive cycles, in order, first one 2 cycles after the first accept. Then hold out_ready=0 for 3 cycles → in_ready drops after 2 further accepts; outputs stay stable; no loss or duplication on release.
- Assert flush with 2 ops in flight and in_valid=1 → out_valid=0 next cycle; the flush-cycle input is not accepted; the next op after flush completes normally.
- Pulse rst_n low mid-stream (async, between edges) → out_valid=0 immediately; sum=0, zero=1; in_ready=1 after release.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared types, default sizes and the flat lookahead carry function for the CLA adder/subtractor.
package adder_pkg;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 2;
    localparam int DEF_GROUP  = 4;
    localparam int MAXG       = 16;
    // Every carry is a flat sum of products from c0, so no carry waits on a neighbour's result.
    function automatic logic [MAXG:0] cla_carry(input logic [MAXG-1:0] g, input logic [MAXG-1:0] p, input logic c0);
        logic [MAXG:0] c;
        logic pp;
        c = '0;
        c[0] = c0;
        for (int i = 0; i < MAXG; i++) begin
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & c0);
        end
        return c;
    endfunction
endpackage

// File: rtl/cla_segment.sv
// cla_segment: combinational SEG-bit carry-lookahead adder built from GROUP-bit lookahead groups.
module cla_segment
    import adder_pkg::*;
#(
    parameter int SEG   = 16,
    parameter int GROUP = 4
) (
    input  logic [SEG-1:0]       i_a,
    input  logic [SEG-1:0]       i_b,
    input  logic                 i_cin,
    output logic [SEG-1:0]       o_sum,
    output logic [SEG/GROUP-1:0] o_g,
    output logic [SEG/GROUP-1:0] o_p,
    output logic                 o_cout,
    output logic                 o_c_msb
);
    localparam int NG = SEG / GROUP;
    logic [SEG-1:0] w_gen, w_prop, w_c;
    logic [MAXG:0]  w_gc;
    logic           w_unused;
    assign w_gen  = i_a & i_b;
    assign w_prop = i_a ^ i_b;
    assign w_gc   = cla_carry(MAXG'(o_g), MAXG'(o_p), i_cin);
    genvar i;
    for (i = 0; i < NG; i++) begin : g_grp
        logic [MAXG-1:0] w_gg, w_gp;
        logic [MAXG:0]   w_bc, w_g0;
        logic            w_unused;
        assign w_gg = MAXG'(w_gen[i*GROUP +: GROUP]);
        assign w_gp = MAXG'(w_prop[i*GROUP +: GROUP]);
        assign w_bc = cla_carry(w_gg, w_gp, w_gc[i]);
        assign w_g0 = cla_carry(w_gg, w_gp, 1'b0);
        assign w_c[i*GROUP +: GROUP] = w_bc[GROUP-1:0];
        assign o_g[i] = w_g0[GROUP];
        assign o_p[i] = &w_prop[i*GROUP +: GROUP];
        assign w_unused = ^{w_bc, w_g0};
    end
    assign o_sum    = w_prop ^ w_c;
    assign o_cout   = w_gc[NG];
    assign o_c_msb  = w_c[SEG-1];
    assign w_unused = ^w_gc;
endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: skewed pipeline of CLA segments with registered inter-segment carry,
// add/sub mode and a valid/ready handshake with flush.
module pipelined_cla_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int GROUP  = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  op_e              i_op,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_negative
);
    localparam int SEG = WIDTH / STAGES;
    localparam int NG  = SEG / GROUP;
    localparam int L   = STAGES - 1;
    if (WIDTH % STAGES != 0 || SEG % GROUP != 0 || GROUP % 4 != 0 || GROUP > MAXG || NG > MAXG) begin : g_bad
        $error("pipelined_cla_addsub: illegal WIDTH/STAGES/GROUP combination");
    end
    logic [WIDTH-1:0] w_b;
    assign w_b = i_b ^ {WIDTH{i_op == OP_SUB}};
    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stg
        localparam int RW = SEG * (k + 1);
        localparam int IW = WIDTH - SEG * k;
        logic          r_valid, w_adv, w_load, w_cin, w_cout, w_cmsb, r_c;
        logic [IW-1:0] w_ia, w_ib;
        logic [SEG-1:0] w_sum;
        logic [RW-1:0] r_res, w_res;
        logic [NG-1:0] w_g_unused, w_p_unused;
        cla_segment #(.SEG(SEG), .GROUP(GROUP)) u_seg (
            .i_a(w_ia[SEG-1:0]), .i_b(w_ib[SEG-1:0]), .i_cin(w_cin), .o_sum(w_sum),
            .o_g(w_g_unused), .o_p(w_p_unused), .o_cout(w_cout), .o_c_msb(w_cmsb)
        );
        if (k == 0) begin : g_first
            assign w_ia   = i_a;
            assign w_ib   = w_b;
            assign w_cin  = i_cin;
            assign w_res  = w_sum;
            assign w_load = i_in_valid & o_in_ready;
        end else begin : g_next
            assign w_ia   = g_stg[k-1].g_up.r_a;
            assign w_ib   = g_stg[k-1].g_up.r_b;
            assign w_cin  = g_stg[k-1].r_c;
            assign w_res  = {w_sum, g_stg[k-1].r_res};
            assign w_load = g_stg[k-1].w_adv;
        end
        if (k == L) begin : g_last
            logic r_cmsb;
            assign w_adv = r_valid & i_out_ready;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_cmsb <= 1'b0;
                else if (w_load) r_cmsb <= w_cmsb;
            end
        end else begin : g_up
            logic [IW-SEG-1:0] r_a, r_b;
            logic              w_unused;
            assign w_unused = w_cmsb;
            assign w_adv = r_valid & (!g_stg[k+1].r_valid | g_stg[k+1].w_adv);
            // Operands still to be summed travel with the op, already inverted for SUB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_load) begin
                    r_a <= w_ia[IW-1:SEG];
                    r_b <= w_ib[IW-1:SEG];
                end
            end
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_res   <= '0;
                r_c     <= 1'b0;
            end else begin
                r_valid <= !i_flush & (w_load | (r_valid & !w_adv));
                if (w_load) begin
                    r_res <= w_res;
                    r_c   <= w_cout;
                end
            end
        end
    end
    assign o_in_ready  = !i_flush & (!g_stg[0].r_valid | g_stg[0].w_adv);
    assign o_out_valid = g_stg[L].r_valid;
    assign o_sum       = g_stg[L].r_res;
    assign o_cout      = g_stg[L].r_c;
    assign o_overflow  = g_stg[L].g_last.r_cmsb ^ g_stg[L].r_c;
    assign o_zero      = ~|o_sum;
    assign o_negative  = o_sum[WIDTH-1];
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: randomized scoreboard bench with an arithmetic reference model,
// plus directed wrap, stall, flush and async-reset scenarios.
module tb_pipelined_cla_addsub;
    import adder_pkg::*;
    localparam int W = 32;
    localparam int S = 2;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, cout, ovf, zero, neg;
    logic [W-1:0] a = '0, b = '0, sum;
    op_e op = OP_ADD;
    int n_checks = 0, n_err = 0, ncyc = 0;
    bit chk_lat = 1'b0, rnd_on = 1'b0;
    typedef struct {logic [W-1:0] s; logic c; logic v; int t;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(W), .STAGES(S), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op(op), .i_cin(cin), .i_a(a), .i_b(b), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_sum(sum), .o_cout(cout), .o_overflow(ovf), .o_zero(zero), .o_negative(neg)
    );

    function automatic exp_t model(op_e o, logic ci, logic [W-1:0] x, logic [W-1:0] y, int t);
        logic [W:0]   r;
        logic [W-1:0] yy;
        exp_t e;
        yy = (o == OP_SUB) ? ~y : y;
        r = {1'b0, x} + {1'b0, yy} + (W+1)'(ci);
        e.s = r[W-1:0];
        e.c = r[W];
        e.v = (x[W-1] == yy[W-1]) && (e.s[W-1] != x[W-1]);
        e.t = t;
        return e;
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkn(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    logic [W-1:0] p_sum;
    logic [3:0]   p_flags;
    bit           p_hold = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!rst_n || flush) begin
            q.delete();
            p_hold = 1'b0;
        end else begin
            if (p_hold) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk("hold_sum", sum, p_sum);
                chk("hold_flags", W'({cout, ovf, zero, neg}), W'(p_flags));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_output: got sum=%h expected no output", sum);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum, e.s);
                    chk1("cout", cout, e.c);
                    chk1("overflow", ovf, e.v);
                    chk1("zero", zero, e.s == '0);
                    chk1("negative", neg, e.s[W-1]);
                    if (chk_lat) chkn("latency", ncyc - e.t, S);
                end
            end
            p_hold  = out_valid && !out_ready;
            p_sum   = sum;
            p_flags = {cout, ovf, zero, neg};
            if (in_valid && in_ready) q.push_back(model(op, cin, a, b, ncyc));
        end
    end

    task automatic send(op_e o, logic ci, logic [W-1:0] x, logic [W-1:0] y);
        int n = 0;
        op = o; cin = ci; a = x; b = y; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk1("send_timeout_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(op_e'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic expect_out(string nm, logic [W-1:0] s, logic c, logic v, logic z);
        int i = 0;
        @(negedge clk);
        while (!out_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk1({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_sum"}, sum, s);
        chk1({nm, "_cout"}, cout, c);
        chk1({nm, "_ovf"}, ovf, v);
        chk1({nm, "_zero"}, zero, z);
        chk1({nm, "_neg"}, neg, s[W-1]);
    endtask

    task automatic drain();
        int i = 0;
        while ((q.size() != 0 || out_valid) && i < 300) begin
            @(negedge clk);
            i++;
        end
        chkn("drain_left", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        bit  full_rdy;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, '0);
        chk1("rst_zero", zero, 1'b1);
        rst_n = 1'b1;
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk("rst_flags", W'({cout, ovf, neg}), '0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        chk_lat = 1'b1;
        send(OP_ADD, 1'b0, 32'h0000FFFF, 32'h00000001);
        expect_out("seg_carry", 32'h00010000, 1'b0, 1'b0, 1'b0);
        send(OP_SUB, 1'b1, 32'h80000000, 32'h00000001);
        expect_out("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        send(OP_ADD, 1'b1, 32'hFFFFFFFF, 32'h00000000);
        expect_out("wrap_cin", 32'h00000000, 1'b1, 1'b0, 1'b1);
        send(OP_ADD, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        expect_out("wrap_b", 32'h00000000, 1'b1, 1'b0, 1'b1);
        send(OP_SUB, 1'b0, 32'h00000005, 32'h00000003);
        expect_out("borrow", 32'h00000001, 1'b1, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 8; i++) send_rand();
        drain();
        chk_lat = 1'b0;
        out_ready = 1'b0;
        acc = 0;
        full_rdy = 1'b1;
        op = OP_ADD; cin = 1'b0; a = $urandom; b = $urandom; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            full_rdy = in_ready;
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            if (full_rdy) begin a = $urandom; b = $urandom; end
        end
        chkn("stall_accepts", acc, 2);
        chk1("full_in_ready", full_rdy, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk1("full_pass_in_ready", in_ready, 1'b1);
        chk1("full_pass_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        out_ready = 1'b0;
        send_rand();
        send_rand();
        flush = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom;
        @(negedge clk);
        chk1("flush_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk1("flush_out_valid", out_valid, 1'b0);
        chk1("flush_after_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        chk_lat = 1'b1;
        send(OP_SUB, 1'b1, 32'h00001000, 32'h00002000);
        expect_out("post_flush", 32'hFFFFF000, 1'b0, 1'b0, 1'b0);
        drain();
        chk_lat = 1'b0;
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                rnd_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        drain();
        out_ready = 1'b0;
        send_rand();
        send_rand();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk1("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_sum", sum, '0);
        chk1("async_rst_zero", zero, 1'b1);
        chk("async_rst_flags", W'({cout, ovf, neg}), '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk1("release_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("release_idle", out_valid, 1'b0);
        end
        @(posedge clk);
        #1 chk_lat = 1'b1;
        send_rand();
        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
